// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, assembles
// 11-bit frames, and folds E0/F0 prefixes into a toggling 11-bit key event word.
`timescale 1ns/1ps
module ps2_key_source #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 49152
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

   logic          clk_s0, clk_s1, data_s0, data_s1;
   logic [FW-1:0] filt_cnt;
   logic          clk_filt, clk_filt_d;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [10:0]   shifter;
   logic          frame_done;
   logic [TW-1:0] idle_cnt;
   logic          timeout;
   logic          ext, rel;
   logic [7:0]    code;

   // start bit low, stop bit high, odd parity over data plus parity bit
   function automatic logic frame_ok(input logic [10:0] f);
      return !f[0] && (^f[9:1]) && f[10];
   endfunction

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_s0  <= 1'b1;
         clk_s1  <= 1'b1;
         data_s0 <= 1'b1;
         data_s1 <= 1'b1;
      end else begin
         clk_s0  <= ps2_clk;
         clk_s1  <= clk_s0;
         data_s0 <= ps2_data;
         data_s1 <= data_s0;
      end
   end

   // the filtered clock flips only after FILTER consecutive samples at the new level
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         filt_cnt   <= '0;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_filt_d <= clk_filt;
         if (clk_s1 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_cnt <= '0;
            clk_filt <= clk_s1;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall    = clk_filt_d & ~clk_filt;
   assign timeout = (bit_cnt != 4'd0) && !fall && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bit_cnt    <= 4'd0;
         shifter    <= 11'h7FF;
         frame_done <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         frame_done <= 1'b0;
         if (fall) begin
            shifter  <= {data_s1, shifter[10:1]};
            idle_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt    <= 4'd0;
               frame_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (timeout) begin
            bit_cnt  <= 4'd0;
            idle_cnt <= '0;
         end else if (bit_cnt != 4'd0) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign code = shifter[8:1];

   // decode runs the cycle after the stop bit lands in the shifter
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ps2_key   <= 11'h000;
         frame_err <= 1'b0;
         ext       <= 1'b0;
         rel       <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (timeout) begin
            frame_err <= 1'b1;
            ext       <= 1'b0;
            rel       <= 1'b0;
         end else if (frame_done) begin
            if (!frame_ok(shifter)) begin
               frame_err <= 1'b1;
               ext       <= 1'b0;
               rel       <= 1'b0;
            end else begin
               case (code)
                  8'hE0:   ext <= 1'b1;
                  8'hF0:   rel <= 1'b1;
                  8'hE1:   ;
                  default: begin
                     ps2_key <= {~ps2_key[10], ~rel, ext, code};
                     ext     <= 1'b0;
                     rel     <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_source.sv
// Directed bench for ps2_key_source: bit-bangs PS/2 frames and checks key words and error pulses.
`timescale 1ns/1ps
module tb_ps2_key_source;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 300;
   localparam int HALF    = 20;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        frame_err;

   int assertions = 0;
   int failures   = 0;
   int err_pulses = 0;
   int key_changes = 0;
   logic mon_en = 1'b0;
   logic [10:0] prev_key = 11'h000;
   int err_base;
   int chg_base;

   ps2_key_source #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .frame_err(frame_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (mon_en) begin
         if (frame_err === 1'b1) err_pulses++;
         if (ps2_key !== prev_key) key_changes++;
         prev_key = ps2_key;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                              input logic bad_start, input logic bad_stop);
      logic par;
      par = (~^b) ^ bad_par;
      return {~bad_stop, par, b, bad_start};
   endfunction

   // glitch_bit selects the bit whose high phase carries a 3-cycle low glitch (-1 = none)
   task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (i == glitch_bit) begin
            wait_cycles(6);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HALF - 9);
         end else begin
            wait_cycles(HALF);
         end
         ps2_clk = 1'b0;
         wait_cycles(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [10:0] f, input int glitch_bit);
      send_bits(f, 11, glitch_bit);
      ps2_data = 1'b1;
      wait_cycles(40);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(make_frame(b, 1'b0, 1'b0, 1'b0), -1);
   endtask

   initial begin
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      reset    = 1'b1;
      wait_cycles(5);
      check("reset_key", 32'(ps2_key), 32'h000);
      check("reset_err", 32'(frame_err), 32'h0);
      reset = 1'b0;
      wait_cycles(2);
      prev_key = ps2_key;
      mon_en   = 1'b1;

      // plain make code: first event sets the toggle bit, pressed, no ext
      err_base = err_pulses;
      send_byte(8'h29);
      check("key_29", 32'(ps2_key), 32'h629);
      check("err_29", 32'(err_pulses - err_base), 32'h0);

      chg_base = key_changes;
      send_byte(8'hE0);
      check("key_after_e0", 32'(ps2_key), 32'h629);
      check("chg_after_e0", 32'(key_changes - chg_base), 32'h0);
      send_byte(8'h75);
      check("key_e0_75", 32'(ps2_key), 32'h375);

      send_byte(8'hE0);
      send_byte(8'hF0);
      check("key_after_e0f0", 32'(ps2_key), 32'h375);
      send_byte(8'h75);
      check("key_e0f0_75", 32'(ps2_key), 32'h575);
      send_byte(8'hF0);
      send_byte(8'hE0);
      send_byte(8'h6B);
      check("key_f0e0_6b", 32'(ps2_key), 32'h16B);

      // bad parity drops the byte and clears the pending E0
      err_base = err_pulses;
      send_byte(8'hE0);
      send_frame(make_frame(8'h1C, 1'b1, 1'b0, 1'b0), -1);
      check("err_parity", 32'(err_pulses - err_base), 32'h1);
      check("key_parity", 32'(ps2_key), 32'h16B);
      send_byte(8'h1C);
      check("key_1c_noext", 32'(ps2_key), 32'h61C);

      err_base = err_pulses;
      send_frame(make_frame(8'h33, 1'b0, 1'b0, 1'b1), -1);
      check("err_stop", 32'(err_pulses - err_base), 32'h1);
      send_frame(make_frame(8'h33, 1'b0, 1'b1, 1'b0), -1);
      check("err_start", 32'(err_pulses - err_base), 32'h2);
      check("key_badframes", 32'(ps2_key), 32'h61C);

      send_byte(8'hE0);
      send_byte(8'hE0);
      send_byte(8'h74);
      check("key_e0e0_74", 32'(ps2_key), 32'h374);

      chg_base = key_changes;
      send_byte(8'hE1);
      check("chg_after_e1", 32'(key_changes - chg_base), 32'h0);
      send_byte(8'h14);
      check("key_e1_14", 32'(ps2_key), 32'h614);

      // partial frame abandoned by the idle timer
      err_base = err_pulses;
      send_bits(make_frame(8'h16, 1'b0, 1'b0, 1'b0), 5, -1);
      ps2_data = 1'b1;
      wait_cycles(TIMEOUT - 60);
      check("err_before_timeout", 32'(err_pulses - err_base), 32'h0);
      wait_cycles(70);
      check("err_timeout", 32'(err_pulses - err_base), 32'h1);
      send_byte(8'h16);
      check("key_after_timeout", 32'(ps2_key), 32'h216);
      check("err_after_timeout", 32'(err_pulses - err_base), 32'h1);

      // glitches on the idle bus and inside a frame are filtered out
      err_base = err_pulses;
      chg_base = key_changes;
      wait_cycles(10);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(TIMEOUT + 100);
      check("err_idle_glitch", 32'(err_pulses - err_base), 32'h0);
      check("chg_idle_glitch", 32'(key_changes - chg_base), 32'h0);
      send_frame(make_frame(8'h45, 1'b0, 1'b0, 1'b0), 3);
      check("key_glitch_45", 32'(ps2_key), 32'h645);
      check("err_glitch", 32'(err_pulses - err_base), 32'h0);
      check("chg_glitch", 32'(key_changes - chg_base), 32'h1);

      // reset mid-frame discards the partial frame
      send_bits(make_frame(8'h5A, 1'b0, 1'b0, 1'b0), 4, -1);
      ps2_data = 1'b1;
      reset    = 1'b1;
      wait_cycles(4);
      check("midreset_key", 32'(ps2_key), 32'h000);
      check("midreset_err", 32'(frame_err), 32'h0);
      reset = 1'b0;
      wait_cycles(5);
      err_base = err_pulses;
      send_byte(8'h29);
      check("key_after_reset", 32'(ps2_key), 32'h629);
      check("err_after_reset", 32'(err_pulses - err_base), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
